// File: rtl/lcd_pkg.sv
// Shared constants, FSM encoding and the ASCII-hex decoder for the LCD
// nibble receiver.
package lcd_pkg;

   localparam logic [1:0] ST_INIT = 2'd0;
   localparam logic [1:0] ST_HI   = 2'd1;
   localparam logic [1:0] ST_LO   = 2'd2;

   localparam logic [7:0] LCD_CMD_CLEAR  = 8'h01;
   localparam logic [7:0] LCD_CMD_HOME   = 8'h02;
   localparam logic [6:0] LCD_LINE2_BASE = 7'h40;

   typedef struct packed {
      logic       ok;
      logic [3:0] val;
   } hex_dec_t;

   // Non-hex characters report ok=0 and value 0.
   function automatic hex_dec_t hex_decode(input logic [7:0] ch);
      hex_dec_t r;
      r.ok  = 1'b1;
      r.val = 4'h0;
      if (ch >= 8'h30 && ch <= 8'h39)
         r.val = ch[3:0];
      else if ((ch >= 8'h41 && ch <= 8'h46) || (ch >= 8'h61 && ch <= 8'h66))
         r.val = ch[3:0] + 4'd9;
      else
         r.ok = 1'b0;
      return r;
   endfunction

endpackage

// File: rtl/lcd_nibble_pair.sv
// Registers the LCD bus, detects qualified falling edges of e and pairs
// nibbles into bytes after discarding the 8-bit-mode init strobes.
module lcd_nibble_pair
   import lcd_pkg::*;
#(
   parameter int INIT_NIBBLES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sf_e,
   input  logic       e,
   input  logic       rs,
   input  logic       r_w,
   input  logic       d,
   input  logic       c,
   input  logic       b,
   input  logic       a,
   output logic [7:0] byte_out,
   output logic       byte_rs,
   output logic       byte_valid,
   output logic       frame_err,
   output logic [1:0] state
);

   logic       s_sf_e, s_e, s_e_d, s_rs, s_r_w;
   logic [3:0] s_nib;
   logic       strobe;
   logic [3:0] init_cnt;
   logic [3:0] hi_nib;
   logic       hi_rs;

   assign strobe = s_e_d & ~s_e & s_sf_e & ~s_r_w;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s_sf_e <= 1'b0;
         s_e    <= 1'b0;
         s_e_d  <= 1'b0;
         s_rs   <= 1'b0;
         s_r_w  <= 1'b0;
         s_nib  <= 4'h0;
      end else begin
         s_sf_e <= sf_e;
         s_e    <= e;
         s_e_d  <= s_e;
         s_rs   <= rs;
         s_r_w  <= r_w;
         s_nib  <= {d, c, b, a};
      end
   end

   // byte_valid and frame_err are single-cycle pulses with no back-pressure;
   // byte_out/byte_rs hold their value until the next assembled byte.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_INIT;
         init_cnt   <= 4'd0;
         hi_nib     <= 4'h0;
         hi_rs      <= 1'b0;
         byte_out   <= 8'h00;
         byte_rs    <= 1'b0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
         if (strobe) begin
            case (state)
               ST_INIT: begin
                  if (init_cnt == 4'(INIT_NIBBLES - 1)) begin
                     init_cnt <= 4'd0;
                     state    <= ST_HI;
                  end else begin
                     init_cnt <= init_cnt + 4'd1;
                  end
               end
               ST_HI: begin
                  hi_nib <= s_nib;
                  hi_rs  <= s_rs;
                  state  <= ST_LO;
               end
               ST_LO: begin
                  if (s_rs == hi_rs) begin
                     byte_out   <= {hi_nib, s_nib};
                     byte_rs    <= s_rs;
                     byte_valid <= 1'b1;
                  end else begin
                     frame_err  <= 1'b1;
                  end
                  state <= ST_HI;
               end
               default: state <= ST_INIT;
            endcase
         end
      end
   end

endmodule

// File: rtl/lcd_nibble_rx.sv
// LCD bus receiver: tracks the DDRAM address and rebuilds the 128-bit hex
// value shown across the two 16-character lines.
module lcd_nibble_rx
   import lcd_pkg::*;
#(
   parameter int INIT_NIBBLES = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         sf_e,
   input  logic         e,
   input  logic         rs,
   input  logic         r_w,
   input  logic         d,
   input  logic         c,
   input  logic         b,
   input  logic         a,
   output logic [7:0]   byte_out,
   output logic         byte_rs,
   output logic         byte_valid,
   output logic         frame_err,
   output logic [127:0] hex_value,
   output logic         hex_valid,
   output logic         hex_err,
   output logic [1:0]   fsm_state
);

   logic [6:0]   addr;
   logic [31:0]  written;
   logic [127:0] shadow;
   logic         map_hit;
   logic [4:0]   map_idx;
   hex_dec_t     dec;
   logic [127:0] shadow_next;
   logic [31:0]  written_next;

   lcd_nibble_pair #(.INIT_NIBBLES(INIT_NIBBLES)) u_pair (
      .clk        (clk),
      .reset      (reset),
      .sf_e       (sf_e),
      .e          (e),
      .rs         (rs),
      .r_w        (r_w),
      .d          (d),
      .c          (c),
      .b          (b),
      .a          (a),
      .byte_out   (byte_out),
      .byte_rs    (byte_rs),
      .byte_valid (byte_valid),
      .frame_err  (frame_err),
      .state      (fsm_state)
   );

   // Line 1 fills the upper 64 bits MSB-first, line 2 the lower 64 bits.
   always_comb begin
      map_hit      = 1'b0;
      map_idx      = 5'd0;
      if (addr[6:4] == 3'b000) begin
         map_hit = 1'b1;
         map_idx = 5'd31 - {1'b0, addr[3:0]};
      end else if (addr[6:4] == LCD_LINE2_BASE[6:4]) begin
         map_hit = 1'b1;
         map_idx = 5'd15 - {1'b0, addr[3:0]};
      end
      dec          = hex_decode(byte_out);
      shadow_next  = shadow;
      shadow_next[{map_idx, 2'b00} +: 4] = dec.ok ? dec.val : 4'h0;
      written_next = written | (32'd1 << map_idx);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr      <= 7'd0;
         written   <= 32'd0;
         shadow    <= 128'd0;
         hex_value <= 128'd0;
         hex_valid <= 1'b0;
         hex_err   <= 1'b0;
      end else begin
         hex_valid <= 1'b0;
         if (byte_valid) begin
            if (!byte_rs) begin
               if (byte_out == LCD_CMD_CLEAR) begin
                  addr    <= 7'd0;
                  written <= 32'd0;
                  hex_err <= 1'b0;
               end else if (byte_out[7:1] == LCD_CMD_HOME[7:1]) begin
                  addr <= 7'd0;
               end else if (byte_out[7]) begin
                  addr <= byte_out[6:0];
               end
            end else begin
               addr <= addr + 7'd1;
               if (map_hit) begin
                  shadow <= shadow_next;
                  if (!dec.ok)
                     hex_err <= 1'b1;
                  if (&written_next) begin
                     hex_value <= shadow_next;
                     hex_valid <= 1'b1;
                     written   <= 32'd0;
                  end else begin
                     written <= written_next;
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_lcd_nibble_rx.sv
// Directed bench for lcd_nibble_rx with byte and hex-frame scoreboards.
module tb_lcd_nibble_rx;
  import lcd_pkg::*;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         sf_e = 1'b0, e = 1'b0, rs = 1'b0, r_w = 1'b0;
  logic         d = 1'b0, c = 1'b0, b = 1'b0, a = 1'b0;
  logic [7:0]   byte_out;
  logic         byte_rs, byte_valid, frame_err;
  logic [127:0] hex_value;
  logic         hex_valid, hex_err;
  logic [1:0]   fsm_state;

  logic [8:0]   exp_q[$];
  logic [127:0] hex_q[$];
  int           errors = 0;
  int           checks = 0;
  int           frame_cnt = 0;
  int           hex_cnt = 0;
  logic         prev_bv = 1'b0;

  localparam logic [127:0] FRAME_OK  = 128'h19a09ae93df4c6f8e3e28d48be2b2a08;
  localparam logic [127:0] FRAME_BAD = 128'h19009ae93df4c6f8e3e28d48be2b2a08;

  lcd_nibble_rx dut (
    .clk        (clk),
    .reset      (reset),
    .sf_e       (sf_e),
    .e          (e),
    .rs         (rs),
    .r_w        (r_w),
    .d          (d),
    .c          (c),
    .b          (b),
    .a          (a),
    .byte_out   (byte_out),
    .byte_rs    (byte_rs),
    .byte_valid (byte_valid),
    .frame_err  (frame_err),
    .hex_value  (hex_value),
    .hex_valid  (hex_valid),
    .hex_err    (hex_err),
    .fsm_state  (fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // scoreboard monitors
  always @(negedge clk) begin
    if (byte_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_byte", {119'd0, byte_rs, byte_out}, 128'h1ff);
      end else begin
        logic [8:0] exp_b;
        exp_b = exp_q.pop_front();
        check("byte", {119'd0, byte_rs, byte_out}, {119'd0, exp_b});
      end
    end
    if (frame_err) frame_cnt++;
    if (hex_valid) begin
      hex_cnt++;
      check("hex_after_byte", {127'd0, prev_bv}, 128'd1);
      if (hex_q.size() == 0) begin
        check("unexpected_hex", hex_value, ~hex_value);
      end else begin
        logic [127:0] exp_h;
        exp_h = hex_q.pop_front();
        check("hex_value", hex_value, exp_h);
      end
    end
    prev_bv = byte_valid;
  end

  // driver tasks
  task automatic send_nibble(input logic rs_v, input logic [3:0] n,
                             input logic sf = 1'b1, input logic rw = 1'b0);
    @(negedge clk);
    rs = rs_v; sf_e = sf; r_w = rw; {d, c, b, a} = n;
    repeat (2) @(negedge clk);
    e = 1'b1;
    repeat (3) @(negedge clk);
    e = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_byte(input logic rs_v, input logic [7:0] v);
    exp_q.push_back({rs_v, v});
    send_nibble(rs_v, v[7:4]);
    send_nibble(rs_v, v[3:0]);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(1'b1, 8'(s[i]));
  endtask

  task automatic send_init();
    send_nibble(1'b0, 4'h3);
    send_nibble(1'b0, 4'h3);
    send_nibble(1'b0, 4'h3);
    send_nibble(1'b0, 4'h2);
  endtask

  // stimulus
  initial begin
    repeat (3) @(negedge clk);
    check("rst_byte_out", {120'd0, byte_out}, 128'd0);
    check("rst_pulses", {124'd0, byte_rs, byte_valid, frame_err, hex_valid}, 128'd0);
    check("rst_hex_value", hex_value, 128'd0);
    check("rst_hex_err", {127'd0, hex_err}, 128'd0);
    check("rst_state", {126'd0, fsm_state}, {126'd0, ST_INIT});
    reset = 1'b1;

    send_init();
    check("init_done_state", {126'd0, fsm_state}, {126'd0, ST_HI});

    // first data byte with exact latency check on the low nibble
    exp_q.push_back(9'h141);
    send_nibble(1'b1, 4'h4);
    @(negedge clk);
    rs = 1'b1; {d, c, b, a} = 4'h1;
    repeat (2) @(negedge clk);
    e = 1'b1;
    repeat (3) @(negedge clk);
    e = 1'b0;
    @(negedge clk);
    check("lat_edge_k", {127'd0, byte_valid}, 128'd0);
    @(negedge clk);
    check("lat_edge_k1", {127'd0, byte_valid}, 128'd1);
    check("lat_byte", {119'd0, byte_rs, byte_out}, 128'h141);
    @(negedge clk);
    check("lat_pulse_end", {127'd0, byte_valid}, 128'd0);

    // ignored strobes, then a command byte must still pair correctly
    send_nibble(1'b0, 4'h5, 1'b0, 1'b0);
    send_nibble(1'b0, 4'h6, 1'b1, 1'b1);
    check("ignored_state", {126'd0, fsm_state}, {126'd0, ST_HI});
    send_byte(1'b0, 8'h80);

    // rs mismatch between nibbles drops the byte
    send_nibble(1'b0, 4'h4);
    send_nibble(1'b1, 4'h1);
    check("frame_err_cnt", 128'(frame_cnt), 128'd1);
    check("frame_err_state", {126'd0, fsm_state}, {126'd0, ST_HI});

    // full frame
    hex_q.push_back(FRAME_OK);
    send_byte(1'b0, 8'h01);
    send_byte(1'b0, 8'h80);
    send_str("19a09ae93df4c6f8");
    send_byte(1'b0, 8'hc0);
    send_str("e3e28d48be2b2a08");
    repeat (2) @(negedge clk);
    check("frame1_hex_cnt", 128'(hex_cnt), 128'd1);
    check("frame1_hex_err", {127'd0, hex_err}, 128'd0);
    check("frame1_hold", hex_value, FRAME_OK);

    // frame with a non-hex character
    hex_q.push_back(FRAME_BAD);
    send_byte(1'b0, 8'h01);
    send_byte(1'b0, 8'h80);
    send_str("19G09ae93df4c6f8");
    check("bad_hex_err_set", {127'd0, hex_err}, 128'd1);
    send_byte(1'b0, 8'hc0);
    send_str("e3e28d48be2b2a08");
    send_byte(1'b0, 8'h80);
    send_str("5");
    check("bad_hex_err_sticky", {127'd0, hex_err}, 128'd1);
    check("frame2_hex_cnt", 128'(hex_cnt), 128'd2);
    send_byte(1'b0, 8'h01);
    check("hex_err_cleared", {127'd0, hex_err}, 128'd0);

    // reset in the middle of a frame
    send_byte(1'b0, 8'h80);
    send_str("ffffffffff");
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_hex_value", hex_value, 128'd0);
    check("midrst_state", {126'd0, fsm_state}, {126'd0, ST_INIT});
    reset = 1'b1;
    send_init();
    hex_q.push_back(FRAME_OK);
    send_byte(1'b0, 8'h80);
    send_str("19a09ae93df4c6f8");
    send_byte(1'b0, 8'hc0);
    send_str("e3e28d48be2b2a08");
    repeat (2) @(negedge clk);
    check("frame3_hex_cnt", 128'(hex_cnt), 128'd3);
    check("frame3_hold", hex_value, FRAME_OK);

    // final report
    check("byte_queue_empty", 128'(exp_q.size()), 128'd0);
    check("hex_queue_empty", 128'(hex_q.size()), 128'd0);
    check("frame_err_total", 128'(frame_cnt), 128'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lcd_nibble_rx.md
# lcd_nibble_rx

Receive-side decoder for the 4-bit character-LCD bus that `mem_io` drives (`sf_e, e, rs, r_w, d, c, b, a`). It samples the bus in the system clock domain and pairs nibbles into command/data bytes. It tracks the LCD DDRAM address and rebuilds the 128-bit hex value shown on the two 16-character lines. It sits beside `mem_io` as an in-system capture and self-check path for the AES ciphertext, and the benches use it as the LCD end of the protocol.

## Interface
- `INIT_NIBBLES`, 4: single-nibble strobes after reset, treated as 8-bit-mode init and discarded.
- `clk` in 1: system clock, all logic on rising edge.
- `reset` in 1: asynchronous, active-low; clears all state and outputs.
- `sf_e` in 1: StrataFlash enable; a strobe counts only when `sf_e`=1.
- `e` in 1: LCD enable; a nibble is taken on its falling edge.
- `rs` in 1: register select; 0 = command, 1 = data.
- `r_w` in 1: 1 = read cycle; the strobe is ignored.
- `d, c, b, a` in 1 each: DB7..DB4 (`d` = MSB).
- `byte_out` out 8: last assembled byte.
- `byte_rs` out 1: `rs` of `byte_out`.
- `byte_valid` out 1: one-cycle pulse, new byte.
- `frame_err` out 1: one-cycle pulse, `rs` mismatch between nibbles; the byte is dropped.
- `hex_value` out 128: last complete 32-character value.
- `hex_valid` out 1: one-cycle pulse, `hex_value` updated.
- `hex_err` out 1: sticky; a non-hex character was written to a mapped position.

## Operation
- Input stage: all eight bus inputs are registered once (`s_*`). A strobe is `s_e_d & ~s_e & s_sf_e & ~s_r_w`. The nibble is `{s_d,s_c,s_b,s_a}`.
- FSM states:
  - INIT: counts strobes. After `INIT_NIBBLES` strobes it goes to HI. No bytes are emitted in INIT.
  - HI: on a strobe, latches the high nibble and `rs`, then goes to LO.
  - LO: on a strobe with matching `rs`, emits a byte and goes to HI. On a strobe with mismatched `rs`, pulses `frame_err`, discards the byte and goes to HI.
- Command bytes (`byte_rs`=0):
  - `0x01` clear: `addr`←0, `written`←0, `hex_err`←0.
  - `0x02`/`0x03` home: `addr`←0.
  - `1xxxxxxx`: `addr`←`byte[6:0]`.
  - Others: emitted, no further effect.
- Data bytes (`byte_rs`=1):
  - Position mapping: `addr` 0x00–0x0F maps to nibble index 31−col. `addr` 0x40–0x4F maps to nibble index 15−col. Other addresses are emitted only.
  - Character decode: ASCII `0-9`, `A-F`, `a-f` → 4-bit value. Any other character at a mapped position sets `hex_err` and still marks the position written with value 0.
  - `addr` increments by 1 after each data byte, 7-bit wrap 0x7F→0x00.
- Hex frame: a 32-bit `written` mask sets per mapped write. A shadow nibble register assembles the value. When all 32 bits are set, `hex_value`←shadow, `hex_valid` pulses, `written`←0. Rewriting a position before completion overwrites its nibble.

## Timing
- Reset values: `byte_out`=0, `byte_rs`=0, `byte_valid`=0, `frame_err`=0, `hex_value`=0, `hex_valid`=0, `hex_err`=0, FSM=INIT, `addr`=0, `written`=0.
- Latency: the strobe is recognised at rising edge k, the first edge at which `s_e` samples 0 after sampling 1. `byte_valid`/`frame_err` are high during the cycle after edge k+1. `hex_valid` is high one cycle after the completing `byte_valid`.
- `e` must be stable high for ≥2 `clk` cycles and low for ≥2 cycles. Shorter pulses are not guaranteed to be seen.
- A strobe with `sf_e`=0 or `r_w`=1 does not advance the FSM.
- Reset asserted mid-byte or mid-frame: the partial nibble, mask and shadow are lost, and decoding restarts in INIT.
- Clear command and completing write cannot coincide; the byte path handles one byte per pulse.

## Structure
- Package `lcd_pkg`: FSM state encoding, `LCD_CMD_CLEAR`=8'h01, `LCD_CMD_HOME`=8'h02, `LCD_LINE2_BASE`=7'h40, and the ASCII-hex decode function.
- One sub-module, `lcd_nibble_pair`: input register, strobe detect, INIT/HI/LO FSM and byte output. The top holds the address tracker, mask and hex assembly.

## Test plan
- Reset → all outputs 0. Four init strobes (0x3,0x3,0x3,0x2) → no `byte_valid`.
- After init, nibbles 0x4,0x1 with `rs`=1 → `byte_out`=0x41, `byte_rs`=1, single `byte_valid` pulse at the specified latency.
- Strobes with `sf_e`=0 or `r_w`=1 → ignored. High nibble with `rs`=0 then low nibble with `rs`=1 → `frame_err` pulse, no byte.
- The following sequence produces one `hex_valid` with `hex_value`=128'h19a09ae93df4c6f8e3e28d48be2b2a08:
  - Clear, then `0x80`, then 16 chars "19a09ae93df4c6f8".
  - Then `0xC0`, then 16 chars "e3e28d48be2b2a08".
- The same frame with one character 'G' → `hex_err`=1, and it stays high until the next `0x01` clears it.
- Reset pulsed after 10 of 32 characters, then a full frame written → exactly one `hex_valid`, value from the new frame only.
